phy_rx_deframer: RTL and testbench

//  Receive-side framing stage that sits directly downstream of the PHY symbol path.
//  It consumes the byte/K-flag symbol stream and strips the STP/SDP/END/EDB framing

---
 rtl/phy_rx_deframer.sv | 228 ++++++++++++++++++++++
 tb/tb_phy_rx_deframer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_deframer.sv
// Receive-side deframer: strips STP/SDP/END/EDB framing from the PHY symbol stream,
// delivers TLP/DLLP payload with SOP/EOP, decodes COM-led ordered sets, counts framing errors.
module phy_rx_deframer #(
  parameter int MAX_TLP_BYTES = 64,
  parameter int MIN_TLP_BYTES = 4,
  parameter int OS_LEN        = 3
) (
  input  logic       clk0_i,
  input  logic       reset_l_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_k_i,
  input  logic       rx_valid_i,
  output logic [7:0] pkt_data_o,
  output logic       pkt_valid_o,
  output logic       pkt_sop_o,
  output logic       pkt_eop_o,
  output logic       pkt_dllp_o,
  output logic       pkt_err_o,
  output logic       os_valid_o,
  output logic [7:0] os_type_o,
  output logic       error_dll_o,
  output logic [7:0] err_count_o
);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_FTS = 8'h3C;

  typedef enum logic [1:0] {S_IDLE, S_TLP, S_DLLP, S_OS} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       held_q, held_d;
  logic       first_q, first_d;
  logic [7:0] byteCnt_q, byteCnt_d;
  logic [7:0] osCnt_q, osCnt_d;
  logic [7:0] osLatch_q, osLatch_d;
  logic [7:0] pktData_q, pktData_d;
  logic       pktValid_q, pktValid_d;
  logic       pktSop_q, pktSop_d;
  logic       pktEop_q, pktEop_d;
  logic       pktDllp_q, pktDllp_d;
  logic       pktErr_q, pktErr_d;
  logic       osValid_q, osValid_d;
  logic [7:0] osType_q, osType_d;
  logic       errorDll_q, errPulse;
  logic [7:0] errCount_q, errCount_d;

  logic isData, isStp, isSdp, isEnd, isEdb, isCom, isOsCode;
  logic tlpOverflow, lenErr, osMatch, osLast;

  assign isData      = !rx_k_i;
  assign isStp       = rx_k_i && (rx_data_i == K_STP);
  assign isSdp       = rx_k_i && (rx_data_i == K_SDP);
  assign isEnd       = rx_k_i && (rx_data_i == K_END);
  assign isEdb       = rx_k_i && (rx_data_i == K_EDB);
  assign isCom       = rx_k_i && (rx_data_i == K_COM);
  assign isOsCode    = rx_k_i && ((rx_data_i == K_SKP) || (rx_data_i == K_IDL) || (rx_data_i == K_FTS));
  // The byte that would become number MAX_TLP_BYTES+1 aborts the TLP instead of being held
  assign tlpOverflow = (state_q == S_TLP) && isData && (byteCnt_q == 8'(MAX_TLP_BYTES));
  assign lenErr      = (state_q == S_TLP) ? (byteCnt_q < 8'(MIN_TLP_BYTES)) : (byteCnt_q != 8'd6);
  assign osMatch     = rx_k_i && (rx_data_i == osLatch_q);
  assign osLast      = (osCnt_q == 8'(OS_LEN - 1));

  always_ff @(posedge clk0_i) begin
    if (!reset_l_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (isStp)      state_d = S_TLP;
          else if (isSdp) state_d = S_DLLP;
          else if (isCom) state_d = S_OS;
        end
        S_TLP, S_DLLP: begin
          if (!isData || tlpOverflow) state_d = S_IDLE;
        end
        S_OS: begin
          if (isCom)                 state_d = S_OS;
          else if (osCnt_q == 8'd0)  state_d = isOsCode ? S_OS : S_IDLE;
          else if (!osMatch || osLast) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hold_d     = hold_q;
    held_d     = held_q;
    first_d    = first_q;
    byteCnt_d  = byteCnt_q;
    osCnt_d    = osCnt_q;
    osLatch_d  = osLatch_q;
    pktData_d  = 8'h00;
    pktValid_d = 1'b0;
    pktSop_d   = 1'b0;
    pktEop_d   = 1'b0;
    pktDllp_d  = 1'b0;
    pktErr_d   = 1'b0;
    osValid_d  = 1'b0;
    osType_d   = osType_q;
    errPulse   = 1'b0;
    if (rx_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (isStp || isSdp) begin
            held_d    = 1'b0;
            first_d   = 1'b1;
            byteCnt_d = 8'd0;
          end else if (isCom) begin
            osCnt_d = 8'd0;
          end else if (!isOsCode) begin
            errPulse = 1'b1;
          end
        end
        S_TLP, S_DLLP: begin
          pktDllp_d = (state_q == S_DLLP) && held_q;
          if (isData && !tlpOverflow) begin
            if (held_q) begin
              pktValid_d = 1'b1;
              pktData_d  = hold_q;
              pktSop_d   = first_q;
              first_d    = 1'b0;
            end
            hold_d    = rx_data_i;
            held_d    = 1'b1;
            byteCnt_d = (byteCnt_q == 8'hFF) ? byteCnt_q : byteCnt_q + 8'd1;
          end else begin
            // Terminating or offending symbol: flush the held byte as the last one
            held_d = 1'b0;
            if (held_q) begin
              pktValid_d = 1'b1;
              pktData_d  = hold_q;
              pktSop_d   = first_q;
              pktEop_d   = 1'b1;
              pktErr_d   = !isEnd || lenErr;
            end
            errPulse = isEnd ? lenErr : !isEdb;
          end
        end
        S_OS: begin
          if (isCom) begin
            osCnt_d  = 8'd0;
            errPulse = 1'b1;
          end else if (osCnt_q == 8'd0) begin
            if (isOsCode) begin
              osLatch_d = rx_data_i;
              osCnt_d   = 8'd1;
            end else begin
              errPulse = 1'b1;
            end
          end else if (osMatch) begin
            if (osLast) begin
              osValid_d = 1'b1;
              osType_d  = osLatch_q;
            end else begin
              osCnt_d = osCnt_q + 8'd1;
            end
          end else begin
            errPulse = 1'b1;
          end
        end
        default: ;
      endcase
    end
    errCount_d = (errPulse && (errCount_q != 8'hFF)) ? errCount_q + 8'd1 : errCount_q;
  end

  always_ff @(posedge clk0_i) begin
    if (!reset_l_i) begin
      hold_q     <= 8'h00;
      held_q     <= 1'b0;
      first_q    <= 1'b0;
      byteCnt_q  <= 8'd0;
      osCnt_q    <= 8'd0;
      osLatch_q  <= 8'h00;
      pktData_q  <= 8'h00;
      pktValid_q <= 1'b0;
      pktSop_q   <= 1'b0;
      pktEop_q   <= 1'b0;
      pktDllp_q  <= 1'b0;
      pktErr_q   <= 1'b0;
      osValid_q  <= 1'b0;
      osType_q   <= 8'h00;
      errorDll_q <= 1'b0;
      errCount_q <= 8'h00;
    end else begin
      hold_q     <= hold_d;
      held_q     <= held_d;
      first_q    <= first_d;
      byteCnt_q  <= byteCnt_d;
      osCnt_q    <= osCnt_d;
      osLatch_q  <= osLatch_d;
      pktData_q  <= pktData_d;
      pktValid_q <= pktValid_d;
      pktSop_q   <= pktSop_d;
      pktEop_q   <= pktEop_d;
      pktDllp_q  <= pktDllp_d;
      pktErr_q   <= pktErr_d;
      osValid_q  <= osValid_d;
      osType_q   <= osType_d;
      errorDll_q <= errPulse;
      errCount_q <= errCount_d;
    end
  end

  assign pkt_data_o  = pktData_q;
  assign pkt_valid_o = pktValid_q;
  assign pkt_sop_o   = pktSop_q;
  assign pkt_eop_o   = pktEop_q;
  assign pkt_dllp_o  = pktDllp_q;
  assign pkt_err_o   = pktErr_q;
  assign os_valid_o  = osValid_q;
  assign os_type_o   = osType_q;
  assign error_dll_o = errorDll_q;
  assign err_count_o = errCount_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Bench for phy_rx_deframer: symbol streams are parsed packet-by-packet by a reference
// model and the registered outputs after every accepted symbol are compared against it.
module tb_phy_rx_deframer;

  localparam int MAX_TLP = 64;
  localparam int MIN_TLP = 4;
  localparam int OS_LEN  = 3;
  localparam int DEPTH   = 4096;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] FTS = 8'h3C;

  logic       clk0 = 1'b0;
  logic       reset_l_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_k_i = 1'b0;
  logic       rx_valid_i = 1'b0;
  logic [7:0] pkt_data_o;
  logic       pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_dllp_o, pkt_err_o;
  logic       os_valid_o, error_dll_o;
  logic [7:0] os_type_o, err_count_o;

  always #5 clk0 = ~clk0;

  phy_rx_deframer #(.MAX_TLP_BYTES(MAX_TLP), .MIN_TLP_BYTES(MIN_TLP), .OS_LEN(OS_LEN)) dut (
    .clk0_i(clk0), .reset_l_i(reset_l_i), .rx_data_i(rx_data_i), .rx_k_i(rx_k_i),
    .rx_valid_i(rx_valid_i), .pkt_data_o(pkt_data_o), .pkt_valid_o(pkt_valid_o),
    .pkt_sop_o(pkt_sop_o), .pkt_eop_o(pkt_eop_o), .pkt_dllp_o(pkt_dllp_o),
    .pkt_err_o(pkt_err_o), .os_valid_o(os_valid_o), .os_type_o(os_type_o),
    .error_dll_o(error_dll_o), .err_count_o(err_count_o)
  );

  int compared = 0;
  int mismatched = 0;

  // Layout: valid,data[8],sop,eop,dllp,err,osValid,osType[8],errDll,errCount[8]
  logic [7:0]  symD [0:DEPTH-1];
  bit          symK [0:DEPTH-1];
  int          symN;
  logic [30:0] expV [0:DEPTH-1];
  logic [30:0] obsV [0:DEPTH-1];
  int          gapNoise;
  int          refErrCount;
  logic [7:0]  refOsType;

  bit          mValid [0:DEPTH-1];
  bit          mSop [0:DEPTH-1];
  bit          mEop [0:DEPTH-1];
  bit          mDllp [0:DEPTH-1];
  bit          mErr [0:DEPTH-1];
  bit          mOs [0:DEPTH-1];
  bit          mErrDll [0:DEPTH-1];
  logic [7:0]  mData [0:DEPTH-1];
  logic [7:0]  mOsT [0:DEPTH-1];
  int          pos[$];

  task automatic addSym(input bit k, input logic [7:0] d);
    symK[symN] = k;
    symD[symN] = d;
    symN++;
  endtask

  task automatic addRandData(input int n);
    for (int i = 0; i < n; i++) addSym(1'b0, 8'($urandom));
  endtask

  function automatic logic [7:0] randOsCode();
    int r;
    r = int'($urandom_range(2));
    return (r == 0) ? SKP : (r == 1) ? IDL : FTS;
  endfunction

  function automatic bit isOsSym(input int j);
    return symK[j] && (symD[j] == SKP || symD[j] == IDL || symD[j] == FTS);
  endfunction

  function automatic logic [30:0] sampleOutputs();
    return {pkt_valid_o, pkt_valid_o ? pkt_data_o : 8'h00, pkt_sop_o, pkt_eop_o,
            pkt_valid_o ? pkt_dllp_o : 1'b0, pkt_err_o, os_valid_o, os_type_o,
            error_dll_o, err_count_o};
  endfunction

  // Packet-level parse: each payload byte is delivered when the next symbol of its
  // packet arrives; the last one carries EOP on the terminating symbol.
  task automatic buildExpected();
    int i, j, nb, cnt;
    bit tlp, ovf, bad, dll, done;
    logic [7:0] typ;
    typ = 8'h00;
    for (int x = 0; x < symN; x++) begin
      mValid[x] = 0; mSop[x] = 0; mEop[x] = 0; mDllp[x] = 0; mErr[x] = 0;
      mOs[x] = 0; mErrDll[x] = 0; mData[x] = 8'h00; mOsT[x] = 8'h00;
    end
    i = 0;
    while (i < symN) begin
      if (symK[i] && (symD[i] == STP || symD[i] == SDP)) begin
        tlp = (symD[i] == STP);
        pos.delete();
        ovf = 0;
        j = i + 1;
        while (j < symN && !symK[j] && !ovf) begin
          if (tlp && pos.size() == MAX_TLP) ovf = 1;
          else begin
            pos.push_back(j);
            j++;
          end
        end
        nb = pos.size();
        for (int m = 0; m < nb - 1; m++) begin
          mValid[pos[m+1]] = 1;
          mData[pos[m+1]]  = symD[pos[m]];
          mSop[pos[m+1]]   = (m == 0);
          mDllp[pos[m+1]]  = !tlp;
        end
        if (j < symN) begin
          if (ovf) begin bad = 1; dll = 1; end
          else if (symK[j] && symD[j] == ENDK) begin
            bad = tlp ? (nb < MIN_TLP) : (nb != 6);
            dll = bad;
          end else if (symK[j] && symD[j] == EDB) begin bad = 1; dll = 0; end
          else begin bad = 1; dll = 1; end
          if (nb > 0) begin
            mValid[j] = 1; mData[j] = symD[pos[nb-1]]; mSop[j] = (nb == 1);
            mEop[j] = 1; mErr[j] = bad; mDllp[j] = !tlp;
          end
          mErrDll[j] = dll;
        end
        i = j + 1;
      end else if (symK[i] && symD[i] == COM) begin
        cnt = 0;
        done = 0;
        j = i + 1;
        while (j < symN && !done) begin
          if (symK[j] && symD[j] == COM) begin mErrDll[j] = 1; cnt = 0; end
          else if (cnt == 0 && isOsSym(j)) begin typ = symD[j]; cnt = 1; end
          else if (cnt > 0 && symK[j] && symD[j] == typ) begin
            cnt++;
            if (cnt == OS_LEN) begin mOs[j] = 1; mOsT[j] = typ; done = 1; end
          end else begin mErrDll[j] = 1; done = 1; end
          j++;
        end
        i = j;
      end else begin
        if (!isOsSym(i)) mErrDll[i] = 1;
        i++;
      end
    end
    for (int x = 0; x < symN; x++) begin
      if (mErrDll[x] && refErrCount < 255) refErrCount++;
      if (mOs[x]) refOsType = mOsT[x];
      expV[x] = {mValid[x], mValid[x] ? mData[x] : 8'h00, mSop[x], mEop[x], mDllp[x], mErr[x],
                 mOs[x], refOsType, mErrDll[x], 8'(refErrCount)};
    end
  endtask

  // Stall cycles must produce no pulses and leave the held outputs untouched
  task automatic driveStream(input int gapPct);
    logic [30:0] last, s;
    last = sampleOutputs();
    gapNoise = 0;
    for (int i = 0; i < symN; i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gapPct; g++) begin
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
        rx_k_i     = 1'($urandom);
        @(posedge clk0); #1;
        s = sampleOutputs();
        if (s[30] || s[21] || s[20] || s[18] || s[17] || s[8] ||
            s[16:9] !== last[16:9] || s[7:0] !== last[7:0]) gapNoise++;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = symD[i];
      rx_k_i     = symK[i];
      @(posedge clk0); #1;
      obsV[i] = sampleOutputs();
      last = obsV[i];
    end
    rx_valid_i = 1'b0;
  endtask

  task automatic doReset();
    reset_l_i  = 1'b0;
    rx_valid_i = 1'b0;
    @(posedge clk0); #1;
    reset_l_i   = 1'b1;
    refErrCount = 0;
    refOsType   = 8'h00;
  endtask

  task automatic test_reset();
    reset_l_i  = 1'b0;
    rx_valid_i = 1'b1;
    rx_k_i     = 1'b1;
    rx_data_i  = STP;
    @(posedge clk0); #1;
    compared++;
    if (sampleOutputs() !== 31'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %h expected %h", sampleOutputs(), 31'h0);
    end
    reset_l_i  = 1'b1;
    rx_valid_i = 1'b0;
    @(posedge clk0); #1;
    compared++;
    if (sampleOutputs() !== 31'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got %h expected %h", sampleOutputs(), 31'h0);
    end
    refErrCount = 0;
    refOsType   = 8'h00;
  endtask

  task automatic test_tlp_frames();
    symN = 0;
    addSym(1, STP); addSym(0, 8'h01); addSym(0, 8'h02); addSym(0, 8'h04); addSym(0, 8'h08); addSym(1, ENDK);
    addSym(1, STP); addSym(0, 8'hAA); addSym(0, 8'hBB); addSym(0, 8'hCC); addSym(0, 8'hDD); addSym(1, EDB);
    buildExpected();
    driveStream(0);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL tlp_frames sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
    compared++;
    if (obsV[2][30:21] !== {1'b1, 8'h01, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL tlp_sop_first: got %h expected %h", obsV[2][30:21], {1'b1, 8'h01, 1'b1});
    end
    compared++;
    if (obsV[5][30:18] !== {1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL tlp_eop_last: got %h expected %h", obsV[5][30:18], {1'b1, 8'h08, 4'b0100});
    end
    compared++;
    if ({obsV[11][30:18], obsV[11][8]} !== {1'b1, 8'hDD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL edb_nullify: got %h expected %h", {obsV[11][30:18], obsV[11][8]},
               {1'b1, 8'hDD, 5'b01010});
    end
  endtask

  task automatic test_dllp();
    doReset();
    symN = 0;
    addSym(1, SDP);
    for (int i = 0; i < 6; i++) addSym(0, 8'(8'h10 + i));
    addSym(1, ENDK);
    addSym(1, SDP);
    for (int i = 0; i < 5; i++) addSym(0, 8'(8'h20 + i));
    addSym(1, ENDK);
    buildExpected();
    driveStream(0);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL dllp sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
    compared++;
    if (obsV[7][30:18] !== {1'b1, 8'h15, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL dllp_good_eop: got %h expected %h", obsV[7][30:18], {1'b1, 8'h15, 4'b0110});
    end
    compared++;
    if ({obsV[14][20], obsV[14][18], obsV[14][8], obsV[14][7:0]} !== {3'b111, 8'd1}) begin
      mismatched++;
      $display("[TB] FAIL dllp_short: got %h expected %h",
               {obsV[14][20], obsV[14][18], obsV[14][8], obsV[14][7:0]}, {3'b111, 8'd1});
    end
  endtask

  task automatic test_ordered_sets();
    symN = 0;
    addSym(1, COM); addSym(1, SKP); addSym(1, SKP); addSym(1, SKP);
    addSym(1, COM); addSym(1, IDL); addSym(1, IDL); addSym(1, SKP);
    addSym(1, COM); addSym(1, FTS); addSym(1, COM); addSym(1, FTS); addSym(1, FTS); addSym(1, FTS);
    buildExpected();
    driveStream(0);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL ordered_sets sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
    compared++;
    if ({obsV[3][17], obsV[3][16:9]} !== {1'b1, 8'h1C}) begin
      mismatched++;
      $display("[TB] FAIL os_skp: got %h expected %h", {obsV[3][17], obsV[3][16:9]}, {1'b1, 8'h1C});
    end
    compared++;
    if ({obsV[7][17], obsV[7][8]} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL os_mismatch: got %b expected %b", {obsV[7][17], obsV[7][8]}, 2'b01);
    end
  endtask

  task automatic test_overflow();
    symN = 0;
    addSym(1, STP);
    addRandData(MAX_TLP + 1);
    addSym(1, ENDK);
    addRandData(2);
    buildExpected();
    driveStream(0);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL overflow sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
    compared++;
    if ({obsV[65][30:22], obsV[65][20], obsV[65][18], obsV[65][8]} !== {1'b1, symD[64], 3'b111}) begin
      mismatched++;
      $display("[TB] FAIL overflow_abort: got %h expected %h",
               {obsV[65][30:22], obsV[65][20], obsV[65][18], obsV[65][8]}, {1'b1, symD[64], 3'b111});
    end
  endtask

  task automatic test_stall_gaps();
    symN = 0;
    addSym(1, STP); addRandData(7); addSym(1, ENDK);
    addSym(1, SDP); addRandData(6); addSym(1, ENDK);
    addSym(1, COM); addSym(1, IDL); addSym(1, IDL); addSym(1, IDL);
    addSym(1, STP); addRandData(1); addSym(1, ENDK);
    buildExpected();
    driveStream(50);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL stall_gaps sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
    compared++;
    if (gapNoise !== 0) begin
      mismatched++;
      $display("[TB] FAIL stall_quiet: got %0d noisy stall cycles expected 0", gapNoise);
    end
  endtask

  task automatic test_reset_mid_packet();
    symN = 0;
    addSym(1, STP); addRandData(3);
    buildExpected();
    driveStream(0);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL pre_reset sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
    reset_l_i  = 1'b0;
    rx_valid_i = 1'b1;
    rx_k_i     = 1'b1;
    rx_data_i  = ENDK;
    @(posedge clk0); #1;
    compared++;
    if (sampleOutputs() !== 31'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_pkt: got %h expected %h", sampleOutputs(), 31'h0);
    end
    reset_l_i   = 1'b1;
    rx_valid_i  = 1'b0;
    refErrCount = 0;
    refOsType   = 8'h00;
    symN = 0;
    addSym(1, STP); addRandData(5); addSym(1, ENDK);
    buildExpected();
    driveStream(0);
    for (int i = 0; i < symN; i++) begin
      compared++;
      if (obsV[i] !== expV[i]) begin
        mismatched++;
        $display("[TB] FAIL post_reset sym %0d: got %h expected %h", i, obsV[i], expV[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] t;
    for (int round = 0; round < 4; round++) begin
      symN = 0;
      for (int item = 0; item < 20; item++) begin
        case ($urandom_range(7))
          0: begin addSym(1, STP); addRandData(int'($urandom_range(8, 1))); addSym(1, ENDK); end
          1: begin addSym(1, SDP); addRandData(int'($urandom_range(8, 4))); addSym(1, ENDK); end
          2: begin addSym(1, STP); addRandData(int'($urandom_range(6, 1))); addSym(1, EDB); end
          3: begin
            t = randOsCode();
            addSym(1, COM);
            for (int s = 0; s < OS_LEN; s++)
              addSym(1, ($urandom_range(9) < 8) ? t : randOsCode());
          end
          4: begin
            case ($urandom_range(2))
              0: addRandData(1);
              1: addSym(1, randOsCode());
              default: addSym(1, ENDK);
            endcase
          end
          5: begin
            addSym(1, $urandom_range(1) ? STP : SDP);
            addRandData(int'($urandom_range(3)));
            case ($urandom_range(3))
              0: addSym(1, STP);
              1: addSym(1, SDP);
              2: addSym(1, COM);
              default: addSym(1, randOsCode());
            endcase
          end
          6: begin addSym(1, STP); addRandData(int'($urandom_range(68, 60))); addSym(1, ENDK); end
          default: begin addSym(1, STP); addRandData(int'($urandom_range(20, 4))); addSym(1, ENDK); end
        endcase
      end
      buildExpected();
      driveStream(20);
      for (int i = 0; i < symN; i++) begin
        compared++;
        if (obsV[i] !== expV[i]) begin
          mismatched++;
          $display("[TB] FAIL random r%0d sym %0d: got %h expected %h", round, i, obsV[i], expV[i]);
        end
      end
      compared++;
      if (gapNoise !== 0) begin
        mismatched++;
        $display("[TB] FAIL random_stall r%0d: got %0d noisy stall cycles expected 0", round, gapNoise);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting phy_rx_deframer bench");
    test_reset();
    test_tlp_frames();
    test_dllp();
    test_ordered_sets();
    test_overflow();
    test_stall_gaps();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
